// File: rtl/multicycle_control_pkg.sv
// Shared opcode map, ALU encodings, FSM state/PC-op types and decode helpers
// for the multicycle_control sequencer.
package multicycle_control_pkg;

    localparam logic [4:0] OP_ADD   = 5'h00;
    localparam logic [4:0] OP_SUB   = 5'h01;
    localparam logic [4:0] OP_ADDI  = 5'h02;
    localparam logic [4:0] OP_SUBI  = 5'h03;
    localparam logic [4:0] OP_MUL2  = 5'h04;
    localparam logic [4:0] OP_DIV2  = 5'h05;
    localparam logic [4:0] OP_CLR   = 5'h06;
    localparam logic [4:0] OP_NOP   = 5'h07;
    localparam logic [4:0] OP_MOV   = 5'h08;
    localparam logic [4:0] OP_JMP   = 5'h09;
    localparam logic [4:0] OP_OUT   = 5'h0A;
    localparam logic [4:0] OP_LOAD  = 5'h0B;
    localparam logic [4:0] OP_STORE = 5'h0C;
    localparam logic [4:0] OP_AND   = 5'h0D;
    localparam logic [4:0] OP_OR    = 5'h0E;
    localparam logic [4:0] OP_XOR   = 5'h0F;
    localparam logic [4:0] OP_JZ    = 5'h10;
    localparam logic [4:0] OP_JN    = 5'h11;
    localparam logic [4:0] OP_JC    = 5'h12;
    localparam logic [4:0] OP_HALT  = 5'h13;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_MUL2 = 3'b010;
    localparam logic [2:0] ALU_DIV2 = 3'b011;
    localparam logic [2:0] ALU_PASS = 3'b100;
    localparam logic [2:0] ALU_AND  = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_XOR  = 3'b111;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_EXECUTE  = 3'd2,
        ST_OUT_WAIT = 3'd3,
        ST_HALTED   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_JUMP = 2'd2
    } pc_op_t;

    // Opcodes whose execution produces fresh ALU flags worth capturing.
    function automatic logic is_alu_op(input logic [4:0] opcode);
        logic alu;
        case (opcode)
            OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_MUL2, OP_DIV2, OP_CLR,
            OP_MOV, OP_AND, OP_OR, OP_XOR: alu = 1'b1;
            default:                       alu = 1'b0;
        endcase
        return alu;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bus between the control sequencer, instruction memory and data_unit.
interface multicycle_control_if #(
    parameter int OPCODE_WIDTH      = 5,
    parameter int SEL_WIDTH         = 3,
    parameter int INSTRUCTION_WIDTH = OPCODE_WIDTH + 2 * SEL_WIDTH,
    parameter int ADDR_BITS_WIDTH   = 6,
    parameter int DATA_WIDTH        = 8
);
    logic [ADDR_BITS_WIDTH-1:0]   instr_addr;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
    logic                         zero_flag;
    logic                         carrier_flag;
    logic                         negative_flag;
    logic [2:0]                   operation_select;
    logic [SEL_WIDTH-1:0]         selector_reg_a;
    logic [SEL_WIDTH-1:0]         selector_reg_b;
    logic [SEL_WIDTH-1:0]         destination_select;
    logic [DATA_WIDTH-1:0]        constant_in;
    logic                         mb_select;
    logic                         md_select;
    logic                         load_enable;
    logic                         ram_enable;
    logic                         output_valid;
    logic                         output_ready;
    logic                         halted;
    logic                         illegal_op;

    modport master (
        output instr_addr, operation_select, selector_reg_a, selector_reg_b,
               destination_select, constant_in, mb_select, md_select,
               load_enable, ram_enable, output_valid, halted, illegal_op,
        input  instruction, zero_flag, carrier_flag, negative_flag, output_ready
    );

    modport slave (
        input  instr_addr, operation_select, selector_reg_a, selector_reg_b,
               destination_select, constant_in, mb_select, md_select,
               load_enable, ram_enable, output_valid, halted, illegal_op,
        output instruction, zero_flag, carrier_flag, negative_flag, output_ready
    );
endinterface

// File: rtl/multicycle_control_pc.sv
// Program counter: hold, increment (wrapping at the top address) or load a jump target.
module multicycle_control_pc
    import multicycle_control_pkg::*;
#(
    parameter int ADDR_BITS_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  pc_op_t                     pc_op,
    input  logic [ADDR_BITS_WIDTH-1:0] jump_target,
    output logic [ADDR_BITS_WIDTH-1:0] pc
);
    localparam logic [ADDR_BITS_WIDTH-1:0] PC_ONE = {{(ADDR_BITS_WIDTH-1){1'b0}}, 1'b1};

    // PC register; increment overflow wraps silently to address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= {ADDR_BITS_WIDTH{1'b0}};
        end else begin
            case (pc_op)
                PC_INC:  pc <= pc + PC_ONE;
                PC_JUMP: pc <= jump_target;
                default: pc <= pc;
            endcase
        end
    end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXECUTE sequencer with OUT handshake and HALT.
// Optional CTRL_PERF_CNT_EN adds saturating retired_count / cycle_count outputs.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPCODE_WIDTH      = 5,
    parameter int SEL_WIDTH         = 3,
    parameter int INSTRUCTION_WIDTH = OPCODE_WIDTH + 2 * SEL_WIDTH,
    parameter int ADDR_BITS_WIDTH   = 6,
    parameter int DATA_WIDTH        = 8
) (
    input  logic        clk,
    input  logic        reset,
`ifdef CTRL_PERF_CNT_EN
    output logic [15:0] retired_count,
    output logic [15:0] cycle_count,
`endif
    multicycle_control_if.master bus
);
    localparam int S = SEL_WIDTH;

    state_t                       state_r, state_next_s;
    pc_op_t                       pc_op_s;
    logic [ADDR_BITS_WIDTH-1:0]   pc_s;
    logic [INSTRUCTION_WIDTH-1:0] instr_r, instr_s;
    logic [OPCODE_WIDTH-1:0]      opcode_s;
    logic [2:0]                   flags_r;          // {zero, carry, negative}
    logic                         flags_we_s, take_jump_s, ctrl_active_s;
    logic                         load_r, ram_r, illegal_r, valid_r, halted_r;
    logic                         load_next_s, ram_next_s, illegal_next_s, valid_next_s, halted_next_s;
    logic [2:0]                   op_s;
    logic [S-1:0]                 sel_a_s, sel_b_s, dest_s;
    logic [DATA_WIDTH-1:0]        const_s;
    logic                         mb_s, md_s;

    // Memory data is only valid during DECODE; afterwards the latched copy is used.
    always_comb begin
        if (state_r == ST_DECODE) begin
            instr_s = bus.instruction;
        end else begin
            instr_s = instr_r;
        end
    end

    assign opcode_s      = instr_s[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
    assign ctrl_active_s = (state_r == ST_DECODE) || (state_r == ST_EXECUTE) || (state_r == ST_OUT_WAIT);

    // Static datapath controls, held from DECODE through the end of the instruction.
    always_comb begin
        op_s    = ALU_ADD;
        sel_a_s = '0;
        sel_b_s = '0;
        dest_s  = '0;
        const_s = '0;
        mb_s    = 1'b0;
        md_s    = 1'b0;
        if (ctrl_active_s) begin
            sel_a_s = instr_s[2*S-1:S];
            sel_b_s = instr_s[S-1:0];
            dest_s  = instr_s[2*S-1:S];
            const_s = DATA_WIDTH'(instr_s[S-1:0]);
            case (opcode_s)
                OP_SUB:   op_s = ALU_SUB;
                OP_ADDI:  mb_s = 1'b1;
                OP_SUBI:  begin op_s = ALU_SUB;  mb_s = 1'b1; end
                OP_MUL2:  begin op_s = ALU_MUL2; mb_s = 1'b1; end
                OP_DIV2:  begin op_s = ALU_DIV2; mb_s = 1'b1; end
                OP_CLR:   begin op_s = ALU_PASS; mb_s = 1'b1; const_s = '0; end
                OP_MOV:   begin op_s = ALU_PASS; sel_a_s = instr_s[S-1:0]; sel_b_s = instr_s[2*S-1:S]; end
                OP_LOAD:  md_s = 1'b1;
                OP_AND:   op_s = ALU_AND;
                OP_OR:    op_s = ALU_OR;
                OP_XOR:   op_s = ALU_XOR;
                default:  op_s = ALU_ADD;
            endcase
        end else begin
            const_s = '0;
        end
    end

    // Conditional jumps look at the registered flags from the last ALU instruction.
    always_comb begin
        case (opcode_s)
            OP_JMP:  take_jump_s = 1'b1;
            OP_JZ:   take_jump_s = flags_r[2];
            OP_JC:   take_jump_s = flags_r[1];
            OP_JN:   take_jump_s = flags_r[0];
            default: take_jump_s = 1'b0;
        endcase
    end

    // Next-state, PC action and next values of the registered strobes.
    always_comb begin
        state_next_s   = state_r;
        pc_op_s        = PC_HOLD;
        flags_we_s     = 1'b0;
        load_next_s    = 1'b0;
        ram_next_s     = 1'b0;
        illegal_next_s = 1'b0;
        valid_next_s   = valid_r;
        halted_next_s  = halted_r;
        case (state_r)
            ST_FETCH: begin
                state_next_s = ST_DECODE;
            end
            ST_DECODE: begin
                state_next_s   = ST_EXECUTE;
                load_next_s    = is_alu_op(opcode_s) || (opcode_s == OP_LOAD);
                ram_next_s     = (opcode_s == OP_LOAD) || (opcode_s == OP_STORE);
                illegal_next_s = (opcode_s > OP_HALT);
            end
            ST_EXECUTE: begin
                flags_we_s = is_alu_op(opcode_s);
                if (opcode_s == OP_OUT) begin
                    state_next_s = ST_OUT_WAIT;
                    valid_next_s = 1'b1;
                end else if (opcode_s == OP_HALT) begin
                    state_next_s  = ST_HALTED;
                    halted_next_s = 1'b1;
                end else begin
                    state_next_s = ST_FETCH;
                    pc_op_s      = take_jump_s ? PC_JUMP : PC_INC;
                end
            end
            ST_OUT_WAIT: begin
                if (bus.output_ready) begin
                    state_next_s = ST_FETCH;
                    pc_op_s      = PC_INC;
                    valid_next_s = 1'b0;
                end else begin
                    state_next_s = ST_OUT_WAIT;
                end
            end
            ST_HALTED: begin
                state_next_s = ST_HALTED;
            end
            default: begin
                state_next_s = ST_FETCH;
            end
        endcase
    end

    // State, latched instruction, flag register and strobe registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_FETCH;
            instr_r   <= '0;
            flags_r   <= 3'b000;
            load_r    <= 1'b0;
            ram_r     <= 1'b0;
            illegal_r <= 1'b0;
            valid_r   <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            load_r    <= load_next_s;
            ram_r     <= ram_next_s;
            illegal_r <= illegal_next_s;
            valid_r   <= valid_next_s;
            halted_r  <= halted_next_s;
            if (state_r == ST_DECODE) begin
                instr_r <= bus.instruction;
            end
            if (flags_we_s) begin
                flags_r <= {bus.zero_flag, bus.carrier_flag, bus.negative_flag};
            end
        end
    end

    multicycle_control_pc #(
        .ADDR_BITS_WIDTH(ADDR_BITS_WIDTH)
    ) u_pc (
        .clk        (clk),
        .rst_n      (reset),
        .pc_op      (pc_op_s),
        .jump_target(instr_s[ADDR_BITS_WIDTH-1:0]),
        .pc         (pc_s)
    );

    assign bus.instr_addr         = pc_s;
    assign bus.operation_select   = op_s;
    assign bus.selector_reg_a     = sel_a_s;
    assign bus.selector_reg_b     = sel_b_s;
    assign bus.destination_select = dest_s;
    assign bus.constant_in        = const_s;
    assign bus.mb_select          = mb_s;
    assign bus.md_select          = md_s;
    assign bus.load_enable        = load_r;
    assign bus.ram_enable         = ram_r;
    assign bus.illegal_op         = illegal_r;
    assign bus.output_valid       = valid_r;
    assign bus.halted             = halted_r;

`ifdef CTRL_PERF_CNT_EN
    logic [15:0] retired_r, cycles_r;
    logic        retire_s;

    assign retire_s = ((state_r == ST_EXECUTE) && (opcode_s != OP_OUT)) ||
                      ((state_r == ST_OUT_WAIT) && bus.output_ready);

    // Saturating retired-instruction and active-cycle counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_r <= 16'h0000;
            cycles_r  <= 16'h0000;
        end else begin
            if (retire_s && (retired_r != 16'hFFFF)) begin
                retired_r <= retired_r + 16'h0001;
            end
            if ((state_r != ST_HALTED) && (cycles_r != 16'hFFFF)) begin
                cycles_r <= cycles_r + 16'h0001;
            end
        end
    end

    assign retired_count = retired_r;
    assign cycle_count   = cycles_r;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed programs, expected events
// queued up front, a negedge monitor compares every strobe / OUT acceptance.
module tb_multicycle_control;

    typedef struct packed {
        logic [5:0] addr;
        logic [2:0] op;
        logic [2:0] dest;
        logic [2:0] sa;
        logic [2:0] sb;
        logic [7:0] k;
        logic       mb;
        logic       md;
        logic       ld;
        logic       rm;
        logic       il;
        logic       out;
        logic [3:0] vc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];

    logic [10:0] mem [64];
    logic [10:0] mem_q;
    logic [63:0] zf_bits, cf_bits, nf_bits;

    always #5 clk = ~clk;

    multicycle_control_if #(.OPCODE_WIDTH(5), .SEL_WIDTH(3), .INSTRUCTION_WIDTH(11),
                            .ADDR_BITS_WIDTH(6), .DATA_WIDTH(8)) bus ();

`ifdef CTRL_PERF_CNT_EN
    logic [15:0] retired_count, cycle_count;
`endif

    multicycle_control #(.OPCODE_WIDTH(5), .SEL_WIDTH(3), .INSTRUCTION_WIDTH(11),
                         .ADDR_BITS_WIDTH(6), .DATA_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (rst_n),
`ifdef CTRL_PERF_CNT_EN
        .retired_count(retired_count),
        .cycle_count  (cycle_count),
`endif
        .bus          (bus)
    );

    // Instruction memory: synchronous read, one cycle latency.
    always @(posedge clk) mem_q <= mem[bus.instr_addr];

    assign bus.instruction   = mem_q;
    assign bus.zero_flag     = zf_bits[bus.instr_addr];
    assign bus.carrier_flag  = cf_bits[bus.instr_addr];
    assign bus.negative_flag = nf_bits[bus.instr_addr];

    function automatic logic [10:0] enc(input logic [4:0] op, input logic [2:0] hi, input logic [2:0] lo);
        return {op, hi, lo};
    endfunction

    function automatic ev_t ev(input logic [5:0] a, input logic [2:0] op, input logic [2:0] d,
                               input logic [2:0] sa, input logic [2:0] sb, input logic [7:0] k,
                               input logic mb, input logic md, input logic ld, input logic rm,
                               input logic il);
        ev_t e;
        e = '0;
        e.addr = a; e.op = op; e.dest = d; e.sa = sa; e.sb = sb; e.k = k;
        e.mb = mb; e.md = md; e.ld = ld; e.rm = rm; e.il = il;
        return e;
    endfunction

    function automatic ev_t ev_out(input logic [5:0] a, input logic [3:0] vc);
        ev_t e;
        e = '0;
        e.addr = a; e.out = 1'b1; e.vc = vc;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Consumer: holds output_ready low for four valid cycles, then accepts.
    initial begin : ready_driver
        int wcnt;
        wcnt = 0;
        bus.output_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.output_valid) begin
                bus.output_ready = (wcnt >= 4);
                wcnt++;
            end else begin
                bus.output_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: every strobe cycle or OUT acceptance is checked against the queue.
    initial begin : monitor
        int   vcnt;
        ev_t  act;
        ev_t  e;
        vcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                vcnt = 0;
            end else begin
                if (bus.output_valid) vcnt++;
                if (bus.load_enable || bus.ram_enable || bus.illegal_op ||
                    (bus.output_valid && bus.output_ready)) begin
                    if (bus.output_valid && bus.output_ready) begin
                        act = ev_out(bus.instr_addr, 4'(vcnt));
                        vcnt = 0;
                    end else begin
                        act = ev(bus.instr_addr, bus.operation_select, bus.destination_select,
                                 bus.selector_reg_a, bus.selector_reg_b, bus.constant_in,
                                 bus.mb_select, bus.md_select, bus.load_enable,
                                 bus.ram_enable, bus.illegal_op);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected actual=%h expected=none", act);
                    end else begin
                        e = exp_q.pop_front();
                        if (act !== e) begin
                            errors++;
                            $display("FAIL sb_event actual=%h expected=%h", act, e);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stimulus
        bit found;
        rst_n   = 1'b0;
        zf_bits = '0; cf_bits = '0; nf_bits = '0;
        for (int i = 0; i < 64; i++) mem[i] = 11'h000;

        // Phase A: main program
        mem[6'h00] = enc(5'h02, 3'd1, 3'd5);   // ADDi r1,#5
        mem[6'h01] = enc(5'h01, 3'd2, 3'd2);   // SUB r2,r2 (zero=1)
        mem[6'h02] = enc(5'h10, 3'd4, 3'd0);   // JZ 0x20 (taken)
        mem[6'h20] = enc(5'h01, 3'd2, 3'd2);   // SUB r2,r2 (zero=0)
        mem[6'h21] = enc(5'h10, 3'd4, 3'd0);   // JZ 0x20 (not taken)
        mem[6'h22] = enc(5'h0A, 3'd3, 3'd0);   // OUT r3
        mem[6'h23] = enc(5'h1A, 3'd0, 3'd0);   // illegal
        mem[6'h24] = enc(5'h08, 3'd4, 3'd6);   // MOV r4,r6
        mem[6'h25] = enc(5'h0B, 3'd5, 3'd1);   // LOAD
        mem[6'h26] = enc(5'h0C, 3'd2, 3'd3);   // STORE
        mem[6'h27] = enc(5'h06, 3'd7, 3'd5);   // CLR r7
        mem[6'h28] = enc(5'h0F, 3'd1, 3'd2);   // XOR
        mem[6'h29] = enc(5'h04, 3'd3, 3'd0);   // MUL2
        mem[6'h2A] = enc(5'h05, 3'd3, 3'd0);   // DIV2 (negative=1)
        mem[6'h2B] = enc(5'h11, 3'd6, 3'd0);   // JN 0x30 (taken)
        mem[6'h30] = enc(5'h0C, 3'd1, 3'd1);   // STORE with live carry=1
        mem[6'h31] = enc(5'h12, 3'd7, 3'd0);   // JC 0x38 (not taken)
        mem[6'h32] = enc(5'h13, 3'd0, 3'd0);   // HALT
        zf_bits[6'h01] = 1'b1;
        nf_bits[6'h2A] = 1'b1;
        cf_bits[6'h30] = 1'b1;

        exp_q.push_back(ev(6'h00, 3'b000, 3'd1, 3'd1, 3'd5, 8'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(6'h01, 3'b001, 3'd2, 3'd2, 3'd2, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(6'h20, 3'b001, 3'd2, 3'd2, 3'd2, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev_out(6'h22, 4'd5));
        exp_q.push_back(ev(6'h23, 3'b000, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(ev(6'h24, 3'b100, 3'd4, 3'd6, 3'd4, 8'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(6'h25, 3'b000, 3'd5, 3'd5, 3'd1, 8'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(ev(6'h26, 3'b000, 3'd2, 3'd2, 3'd3, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(ev(6'h27, 3'b100, 3'd7, 3'd7, 3'd5, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(6'h28, 3'b111, 3'd1, 3'd1, 3'd2, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(6'h29, 3'b010, 3'd3, 3'd3, 3'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(6'h2A, 3'b011, 3'd3, 3'd3, 3'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(6'h30, 3'b000, 3'd1, 3'd1, 3'd1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

        repeat (3) @(negedge clk);
        check("rst_addr", 32'(bus.instr_addr), 32'h0);
        check("rst_strobes", {27'd0, bus.load_enable, bus.ram_enable, bus.illegal_op,
                              bus.output_valid, bus.halted}, 32'h0);
        check("rst_ctrl", {14'd0, bus.operation_select, bus.mb_select, bus.md_select,
                           bus.destination_select, bus.selector_reg_a, bus.constant_in}, 32'h0);
`ifdef CTRL_PERF_CNT_EN
        check("rst_perf", {retired_count, cycle_count}, 32'h0);
`endif
        rst_n = 1'b1;
        @(negedge clk);   // DECODE of ADDi r1,#5
        check("decode_addi", {19'd0, bus.mb_select, bus.constant_in, bus.destination_select,
                              bus.load_enable}, {19'd0, 1'b1, 8'd5, 3'd1, 1'b0});
        @(negedge clk);   // EXECUTE
        check("exec_addi_load", 32'(bus.load_enable), 32'h1);
        @(negedge clk);   // next FETCH
        check("addr_after_addi", {25'd0, bus.load_enable, bus.instr_addr}, {25'd0, 1'b0, 6'h01});

        for (int i = 0; i < 400 && !bus.halted; i++) @(negedge clk);
        check("halt_reached", 32'(bus.halted), 32'h1);
        check("sb_drained_a", exp_q.size(), 32'h0);
`ifdef CTRL_PERF_CNT_EN
        check("perf_retired", 32'(retired_count), 32'd18);
        check("perf_cycles", 32'(cycle_count), 32'd59);
`endif
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_hold", {23'd0, bus.halted, bus.instr_addr, bus.load_enable,
                                bus.ram_enable}, {23'd0, 1'b1, 6'h32, 1'b0, 1'b0});
        end

        // Phase B: PC wrap, then reset in the middle of a STORE
        rst_n = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 11'h000;
        zf_bits = '0; cf_bits = '0; nf_bits = '0;
        mem[6'h00] = enc(5'h09, 3'd7, 3'd7);   // JMP 0x3F
        mem[6'h3F] = enc(5'h07, 3'd0, 3'd0);   // NOP
        repeat (2) @(negedge clk);
        check("rst2_halted", 32'(bus.halted), 32'h0);
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (bus.instr_addr == 6'h3F) found = 1'b1;
        end
        check("jmp_to_63", 32'(found), 32'h1);
        repeat (3) @(negedge clk);
        check("pc_wrap", 32'(bus.instr_addr), 32'h0);

        mem[6'h00] = enc(5'h0C, 3'd1, 3'd2);   // STORE, interrupted by reset
        mem[6'h01] = enc(5'h13, 3'd0, 3'd0);   // HALT
        @(posedge clk);   // -> DECODE
        @(posedge clk);   // -> EXECUTE
        #1;
        check("store_ram_pre", 32'(bus.ram_enable), 32'h1);
        rst_n = 1'b0;
        #1;
        check("store_abort", {25'd0, bus.ram_enable, bus.instr_addr}, 32'h0);
`ifdef CTRL_PERF_CNT_EN
        check("abort_perf", {retired_count, cycle_count}, 32'h0);
`endif
        exp_q.push_back(ev(6'h00, 3'b000, 3'd1, 3'd1, 3'd2, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50 && !bus.halted; i++) @(negedge clk);
        check("halt_b", {25'd0, bus.halted, bus.instr_addr}, {25'd0, 1'b1, 6'h01});
        check("sb_drained_b", exp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle control sequencer for the accumulator-style processor.
- Owns the PC and a FETCH/DECODE/EXECUTE state machine, drives data_unit control lines, and registers ALU flags for conditional jumps.
- Adds HALT and an output ready/valid handshake.
- Sits between instruction_memory (synchronous read, 1-cycle latency) and data_unit; replaces the standalone pc instance.

Parameters:
- OPCODE_WIDTH, 5, opcode field width (top bits of instruction).
- SEL_WIDTH, 3, register selector field width.
- INSTRUCTION_WIDTH, OPCODE_WIDTH+2*SEL_WIDTH (11), instruction word width.
- ADDR_BITS_WIDTH, 6, PC / jump target width; must be <= 2*SEL_WIDTH.
- DATA_WIDTH, 8, constant_in width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_addr  out  ADDR_BITS_WIDTH  PC presented to instruction memory.
- instruction  in  INSTRUCTION_WIDTH  memory read data, valid one cycle after instr_addr.
- zero_flag, carrier_flag, negative_flag  in  1 each  data_unit flags.
- operation_select  out  3  ALU op.
- selector_reg_a, selector_reg_b, destination_select  out  SEL_WIDTH  register selects.
- constant_in  out  DATA_WIDTH  zero-extended immediate (instr[SEL_WIDTH-1:0]).
- mb_select, md_select  out  1  B-mux / D-mux selects.
- load_enable, ram_enable  out  1  register-file / RAM write strobes.
- output_valid  out  1  data_unit output is valid.
- output_ready  in  1  consumer accepts output.
- halted  out  1  core stopped.
- illegal_op  out  1  one-cycle pulse on undefined opcode.

Behaviour:
- Reset (async, reset=0): state FETCH, pc 0, flag register 0, all outputs 0.
- States and transitions:
  - FETCH: instr_addr=pc. Always goes to DECODE (absorbs the memory latency).
  - DECODE: latch instruction; drive the static controls (selects, op, mux, constant); load_enable/ram_enable stay 0. Goes to EXECUTE.
  - EXECUTE: one-cycle pulse of load_enable/ram_enable per opcode; update pc; then FETCH. Exceptions: OUT goes to OUT_WAIT, HALT goes to HALTED.
  - OUT_WAIT: output_valid=1 until the cycle output_ready=1, then pc+1 and FETCH. output_valid drops the cycle after acceptance.
  - HALTED: halted=1, all strobes 0. Leaves only on reset.
- Throughput: 3 cycles per instruction, plus OUT_WAIT cycles.
- Opcode map and controls:
  - 0x00 ADD, 0x01 SUB: op 000/001; reg-reg, dest=a=instr[2S-1:S], b=instr[S-1:0], load.
  - 0x02 ADDi, 0x03 SUBi: op 000/001; mb=1, load.
  - 0x04 MUL2: op 010, mb=1, load.
  - 0x05 DIV2: op 011, mb=1, load.
  - 0x06 CLR: op 100, constant 0, mb=1, load.
  - 0x07 NOP.
  - 0x08 MOV: op 100, a=src, b=dest, load.
  - 0x09 JMP: unconditional jump.
  - 0x0A OUT.
  - 0x0B LOAD: md=1, ram, load.
  - 0x0C STORE: ram, no load.
  - 0x0D AND, 0x0E OR, 0x0F XOR: op 101/110/111, load.
  - 0x10 JZ, 0x11 JN, 0x12 JC: conditional jumps.
  - 0x13 HALT.
  - 0x14–0x1F: illegal; executed as NOP with illegal_op pulsed during EXECUTE.
- Flag register: captured at end of EXECUTE for ALU opcodes only (0x00–0x06, 0x08, 0x0D–0x0F); held otherwise.
- Conditional jumps test the flag register, not the live flags.
- Jumps: taken means pc<=instr[ADDR_BITS_WIDTH-1:0]; otherwise pc<=pc+1.
- PC wrap: pc+1 at max address wraps to 0, no flag.
- Jump to own address is legal (spin).
- Reset during EXECUTE aborts the strobes immediately; no partial write is guaranteed beyond that edge.

Optional Feature:
- CTRL_PERF_CNT_EN defined: adds output retired_count (16 bits) and cycle_count (16 bits).
  - retired_count increments on every instruction completion: EXECUTE exit or OUT_WAIT acceptance.
  - cycle_count increments every non-HALTED cycle.
  - Both saturate at 0xFFFF and reset to 0.
- Undefined: ports absent, no counter logic.

Decomposition:
- Package ctrl_pkg: opcode localparams, ALU op encodings (3'b000–3'b111), state encoding enum, is_alu_op function.
- One sub-module: ctrl_pc (pc register with jump/increment/wrap/hold).
- Decode stays in the main FSM.

Test Plan:
- Reset, then ADDi r1,#5 (0x02,001,101) -> DECODE cycle shows mb_select=1, constant_in=5, dest=1; load_enable high exactly one cycle in EXECUTE; next instr_addr=1 three cycles after start.
- SUB r2,r2 with zero_flag=1 in EXECUTE, then JZ 0x20 -> instr_addr=0x20; same sequence with zero_flag=0 -> instr_addr=pc+1.
- OUT with output_ready low 4 cycles -> output_valid high 4+1 cycles, pc held, advances only after accept.
- pc at 63 executing NOP -> instr_addr wraps to 0.
- Opcode 0x1A -> illegal_op pulses one cycle, no strobes, pc+1. HALT -> halted=1, instr_addr frozen, strobes 0 for 20 cycles.
- Assert reset mid-EXECUTE of STORE -> ram_enable drops asynchronously, pc=0, state FETCH; perf counters (if CTRL_PERF_CNT_EN) read 0.
